// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the IF/ID/EXE/MEM pipeline: load-use stall,
// taken-branch flush, per-operand EXE forwarding selects and saturating event counters.
module pipe_hazard_unit #(
    parameter  int REG_ADDR  = 3,
    parameter  int NSRC      = 3,
    parameter  int FWD_DEPTH = 2,
    parameter  int R0_ZERO   = 0,
    parameter  int CNT_W     = 16,
    localparam int FSW       = $clog2(FWD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_en,
    input  logic                     id_valid,
    input  logic [NSRC*REG_ADDR-1:0] id_src_addr,
    input  logic [NSRC-1:0]          id_src_used,
    input  logic                     id_wb_en,
    input  logic [REG_ADDR-1:0]      id_wb_dest,
    input  logic                     id_rd_mem,
    input  logic                     branch_taken,
    input  logic                     cnt_clr,
    output logic                     pc_en_out,
    output logic                     ifid_stall,
    output logic                     ifid_flush,
    output logic                     idexe_flush,
    output logic [NSRC*FSW-1:0]      fwd_sel,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [FWD_DEPTH-1:0]               sb_vld_q, sb_vld_d;
    logic [FWD_DEPTH-1:0]               sb_wb_q, sb_wb_d;
    logic [FWD_DEPTH-1:0][REG_ADDR-1:0] sb_dest_q, sb_dest_d;
    // Only the EXE entry's load flag can ever create a load-use stall.
    logic                               exe_load_q, exe_load_d;
    logic [NSRC*FSW-1:0]                fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]                   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]                   flush_cnt_q, flush_cnt_d;

    logic [NSRC-1:0][FWD_DEPTH-1:0]     match;
    logic                               loaduse;
    logic                               issue;

    always_comb begin
        match   = '0;
        loaduse = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                match[i][k] = id_src_used[i] && sb_vld_q[k] && sb_wb_q[k]
                              && (sb_dest_q[k] == id_src_addr[i*REG_ADDR +: REG_ADDR])
                              && !((R0_ZERO != 0) && (sb_dest_q[k] == '0));
            end
            if (match[i][0]) loaduse = id_valid & exe_load_q;
        end
    end

    always_comb begin
        pc_en_out   = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
        end else if (!pipe_en) begin
            ifid_stall = 1'b1;
        end else if (branch_taken) begin
            pc_en_out   = 1'b1;
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
        end else if (loaduse) begin
            ifid_stall  = 1'b1;
            idexe_flush = 1'b1;
        end else begin
            pc_en_out = 1'b1;
        end
    end

    always_comb begin
        issue = id_valid & ~branch_taken & ~loaduse;
        for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
            sb_vld_d[k]  = sb_vld_q[k-1];
            sb_wb_d[k]   = sb_wb_q[k-1];
            sb_dest_d[k] = sb_dest_q[k-1];
        end
        sb_vld_d[0]  = issue;
        sb_wb_d[0]   = issue & id_wb_en;
        sb_dest_d[0] = issue ? id_wb_dest : '0;
        exe_load_d   = issue & id_rd_mem;

        // Descending scan so the nearest producer overwrites farther ones.
        fwd_sel_d = '0;
        if (issue) begin
            for (int i = 0; i < NSRC; i++) begin
                for (int k = FWD_DEPTH; k >= 1; k--) begin
                    if (match[i][k-1]) fwd_sel_d[i*FSW +: FSW] = FSW'(k);
                end
            end
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pipe_en && loaduse && !branch_taken) stall_cnt_d = sat_inc(stall_cnt_q);
        if (pipe_en && branch_taken)             flush_cnt_d = sat_inc(flush_cnt_q);
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_vld_q    <= '0;
            sb_wb_q     <= '0;
            sb_dest_q   <= '0;
            exe_load_q  <= 1'b0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pipe_en) begin
                sb_vld_q   <= sb_vld_d;
                sb_wb_q    <= sb_wb_d;
                sb_dest_q  <= sb_dest_d;
                exe_load_q <= exe_load_d;
                fwd_sel_q  <= fwd_sel_d;
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: two instances (R0_ZERO=0/1, CNT_W=4) share stimulus;
// an instruction-history reference model queues expectations, a negedge monitor checks them.
module tb_pipe_hazard_unit;
    localparam int RA = 3, NS = 3, FD = 2, CW = 4, FS = 2, FW = NS * FS;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, pipe_en, id_valid, id_wb_en, id_rd_mem, branch_taken, cnt_clr;
    logic [NS*RA-1:0] id_src_addr;
    logic [NS-1:0] id_src_used;
    logic [RA-1:0] id_wb_dest;

    logic [1:0]    pc_w, st_w, iff_w, ief_w;
    logic [FW-1:0] fwd_w [2];
    logic [CW-1:0] sc_w [2];
    logic [CW-1:0] fc_w [2];

    pipe_hazard_unit #(.REG_ADDR(RA), .NSRC(NS), .FWD_DEPTH(FD), .R0_ZERO(0), .CNT_W(CW)) u0 (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_wb_en(id_wb_en), .id_wb_dest(id_wb_dest), .id_rd_mem(id_rd_mem),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr), .pc_en_out(pc_w[0]), .ifid_stall(st_w[0]),
        .ifid_flush(iff_w[0]), .idexe_flush(ief_w[0]), .fwd_sel(fwd_w[0]), .stall_cnt(sc_w[0]),
        .flush_cnt(fc_w[0]));

    pipe_hazard_unit #(.REG_ADDR(RA), .NSRC(NS), .FWD_DEPTH(FD), .R0_ZERO(1), .CNT_W(CW)) u1 (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_wb_en(id_wb_en), .id_wb_dest(id_wb_dest), .id_rd_mem(id_rd_mem),
        .branch_taken(branch_taken), .cnt_clr(cnt_clr), .pc_en_out(pc_w[1]), .ifid_stall(st_w[1]),
        .ifid_flush(iff_w[1]), .idexe_flush(ief_w[1]), .fwd_sel(fwd_w[1]), .stall_cnt(sc_w[1]),
        .flush_cnt(fc_w[1]));

    // Model: history of issued instructions, hist[d][k-1] = instruction k ahead of ID.
    typedef struct packed { logic v; logic wb; logic [RA-1:0] dest; logic ld; } ent_t;
    ent_t          hist  [2][FD];
    ent_t          nhist [2][FD];
    logic [FW-1:0] m_fwd [2];
    logic [FW-1:0] n_fwd [2];
    int            m_sc [2], m_fc [2], n_sc [2], n_fc [2];

    typedef struct { int d; logic [3:0] ctrl; logic [FW-1:0] fwd; logic [CW-1:0] sc; logic [CW-1:0] fc; } exp_t;
    exp_t expq [$];

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, int d, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h required %0h", name, d, act, req);
        end
    endfunction

    // Instance d=1 treats r0 as hard-wired zero.
    function automatic logic hit(int d, int i, int k);
        logic [RA-1:0] s;
        s = id_src_addr[i*RA +: RA];
        if (d == 1 && s == 0) return 1'b0;
        return id_src_used[i] && hist[d][k].v && hist[d][k].wb && (hist[d][k].dest == s);
    endfunction

    task automatic cycle();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            logic lu;
            logic issue;
            if (rst) begin
                for (int k = 0; k < FD; k++) hist[d][k] = '0;
                m_fwd[d] = '0; m_sc[d] = 0; m_fc[d] = 0;
            end
            lu = 1'b0;
            for (int i = 0; i < NS; i++)
                if (id_valid && hist[d][0].ld && hit(d, i, 0)) lu = 1'b1;
            e.d = d;
            if (rst)               e.ctrl = 4'b0011;
            else if (!pipe_en)     e.ctrl = 4'b0100;
            else if (branch_taken) e.ctrl = 4'b1011;
            else if (lu)           e.ctrl = 4'b0101;
            else                   e.ctrl = 4'b1000;
            e.fwd = m_fwd[d];
            e.sc  = m_sc[d][CW-1:0];
            e.fc  = m_fc[d][CW-1:0];
            expq.push_back(e);

            for (int k = 0; k < FD; k++) nhist[d][k] = hist[d][k];
            n_fwd[d] = m_fwd[d]; n_sc[d] = m_sc[d]; n_fc[d] = m_fc[d];
            if (!rst && pipe_en) begin
                issue = id_valid && !branch_taken && !lu;
                n_fwd[d] = '0;
                if (issue)
                    for (int i = 0; i < NS; i++)
                        for (int k = FD; k >= 1; k--)
                            if (hit(d, i, k - 1)) n_fwd[d][i*FS +: FS] = FS'(k);
                for (int k = FD - 1; k >= 1; k--) nhist[d][k] = hist[d][k-1];
                nhist[d][0] = issue ? {1'b1, id_wb_en, id_wb_dest, id_rd_mem} : '0;
                if (lu && !branch_taken) n_sc[d] = (m_sc[d] + 1 > CMAX) ? CMAX : m_sc[d] + 1;
                if (branch_taken)        n_fc[d] = (m_fc[d] + 1 > CMAX) ? CMAX : m_fc[d] + 1;
            end
            if (rst || cnt_clr) begin n_sc[d] = 0; n_fc[d] = 0; end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < FD; k++) hist[d][k] = nhist[d][k];
            m_fwd[d] = n_fwd[d]; m_sc[d] = n_sc[d]; m_fc[d] = n_fc[d];
        end
        #1;
    endtask

    task automatic instr(input logic v, input logic wb, input int dest, input logic ld,
                         input logic [2:0] used, input int s0, input int s1, input int s2);
        id_valid    = v;
        id_wb_en    = wb;
        id_wb_dest  = RA'(dest);
        id_rd_mem   = ld;
        id_src_used = used;
        id_src_addr = {RA'(s2), RA'(s1), RA'(s0)};
        cycle();
    endtask

    task automatic nop();
        instr(1'b0, 1'b0, 0, 1'b0, 3'b000, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            chk("ctrl{pc,stall,ifflush,exflush}", e.d,
                {28'd0, pc_w[e.d], st_w[e.d], iff_w[e.d], ief_w[e.d]}, {28'd0, e.ctrl});
            chk("fwd_sel", e.d, 32'(fwd_w[e.d]), 32'(e.fwd));
            chk("stall_cnt", e.d, 32'(sc_w[e.d]), 32'(e.sc));
            chk("flush_cnt", e.d, 32'(fc_w[e.d]), 32'(e.fc));
        end
    end

    initial begin
        rst = 1'b1; pipe_en = 1'b1; branch_taken = 1'b0; cnt_clr = 1'b0;
        id_valid = 1'b0; id_wb_en = 1'b0; id_wb_dest = '0; id_rd_mem = 1'b0;
        id_src_used = '0; id_src_addr = '0;
        @(posedge clk); #1;
        nop(); nop();
        rst = 1'b0;
        nop(); nop();

        // ALU chain, adjacent and with one independent op between
        instr(1, 1, 1, 0, 3'b000, 0, 0, 0);
        instr(1, 1, 2, 0, 3'b011, 1, 1, 0);
        chk("alu_adj_fwd", 0, 32'(fwd_w[0]), 32'h05);
        instr(1, 1, 1, 0, 3'b000, 0, 0, 0);
        instr(1, 1, 4, 0, 3'b000, 0, 0, 0);
        instr(1, 1, 2, 0, 3'b011, 1, 1, 0);
        chk("alu_gap_fwd", 0, 32'(fwd_w[0]), 32'h0a);
        nop();

        // Load-use: consumer held in ID through one bubble
        instr(1, 1, 3, 1, 3'b000, 0, 0, 0);
        instr(1, 1, 5, 0, 3'b100, 0, 0, 3);
        chk("lu_stall_cnt", 0, 32'(sc_w[0]), 32'd1);
        instr(1, 1, 5, 0, 3'b100, 0, 0, 3);
        chk("lu_fwd", 0, 32'(fwd_w[0]), 32'h20);
        nop();

        // Branch in the same cycle as a load-use condition
        instr(1, 1, 6, 1, 3'b000, 0, 0, 0);
        branch_taken = 1'b1;
        instr(1, 1, 7, 0, 3'b001, 6, 0, 0);
        branch_taken = 1'b0;
        chk("br_flush_cnt", 0, 32'(fc_w[0]), 32'd1);
        chk("br_stall_cnt", 0, 32'(sc_w[0]), 32'd1);
        instr(1, 1, 2, 0, 3'b011, 7, 6, 0);
        nop();

        // r0 producer/consumer
        instr(1, 1, 0, 0, 3'b000, 0, 0, 0);
        instr(1, 1, 5, 0, 3'b001, 0, 0, 0);
        chk("r0_fwd_r0zero0", 0, 32'(fwd_w[0]), 32'h01);
        chk("r0_fwd_r0zero1", 1, 32'(fwd_w[1]), 32'h00);
        nop();

        // Counter saturation, freeze, clear
        branch_taken = 1'b1;
        repeat (20) nop();
        branch_taken = 1'b0;
        chk("flush_sat", 0, 32'(fc_w[0]), 32'd15);
        instr(1, 1, 3, 1, 3'b000, 0, 0, 0);
        pipe_en = 1'b0;
        repeat (3) instr(1, 1, 4, 0, 3'b001, 3, 0, 0);
        pipe_en = 1'b1;
        instr(1, 1, 4, 0, 3'b001, 3, 0, 0);
        instr(1, 1, 4, 0, 3'b001, 3, 0, 0);
        cnt_clr = 1'b1;
        nop();
        cnt_clr = 1'b0;
        chk("clr_flush", 0, 32'(fc_w[0]), 32'd0);
        chk("clr_stall", 0, 32'(sc_w[0]), 32'd0);

        // Randomized traffic with occasional reset, freeze and clear
        for (int n = 0; n < 500; n++) begin
            rst          = ($urandom_range(0, 99) < 2);
            pipe_en      = ($urandom_range(0, 99) < 90);
            branch_taken = ($urandom_range(0, 99) < 15);
            cnt_clr      = ($urandom_range(0, 99) < 3);
            instr($urandom_range(0, 99) < 85, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                  $urandom_range(0, 99) < 35, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        rst = 1'b0; pipe_en = 1'b1; branch_taken = 1'b0; cnt_clr = 1'b0;
        nop(); nop();

        @(negedge clk); #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the in-order IF/ID/EXE/MEM pipeline. It replaces the tied-off IF/ID flush and free-running PC enable with real control: PC/IF-ID stall on load-use, IF/ID and ID/EXE flush on taken branch, and per-operand forwarding selects for the EXE stage. It keeps a shadow scoreboard of in-flight destinations and saturating stall/flush event counters. It sits beside the decoder and drives the PC enable and the IFID/IDEXE pipe control inputs.

## Interface
- REG_ADDR, 3: register index width (8 registers).
- NSRC, 3: source operands per instruction (src1..src3).
- FWD_DEPTH, 2: downstream stages tracked and forwardable (1 = EXE/MEM output, 2 = next stage).
- R0_ZERO, 0: if 1, destination index 0 never creates a dependency.
- CNT_W, 16: event counter width.
- FSW: derived, $clog2(FWD_DEPTH+1), width of one forwarding select.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pipe_en  in  1  global run enable; low freezes the unit.
- id_valid  in  1  ID stage holds a real instruction.
- id_src_addr  in  NSRC*REG_ADDR  source indices, src i at [i*REG_ADDR +: REG_ADDR].
- id_src_used  in  NSRC  bit i set when src i is actually read.
- id_wb_en  in  1  ID instruction writes a register.
- id_wb_dest  in  REG_ADDR  ID destination index.
- id_rd_mem  in  1  ID instruction is a load.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_en_out  out  1  PC advance enable.
- ifid_stall  out  1  IF/ID register holds.
- ifid_flush  out  1  IF/ID register loads a bubble.
- idexe_flush  out  1  ID/EXE register loads a bubble.
- fwd_sel  out  NSRC*FSW  per-source select for the instruction now in EXE: 0 = decoded value, k = result of instruction k ahead.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  branch flush events, saturating.

## Operation
- Scoreboard: FWD_DEPTH entries {valid, wb_en, dest, load}; entry 0 = instruction now in EXE, entry k-1 = k instructions ahead of ID.
- Match(i,k): id_src_used[i] and sb[k].valid and sb[k].wb_en and sb[k].dest == src i, and not (R0_ZERO and dest == 0).
- Load-use hazard: id_valid and any i with Match(i,0) and sb[0].load.
- Control, combinational from inputs and scoreboard:
  - branch_taken: ifid_flush=1, idexe_flush=1, pc_en_out=pipe_en, ifid_stall=0. Branch beats stall.
  - else load-use: pc_en_out=0, ifid_stall=1, idexe_flush=1, ifid_flush=0.
  - else: pc_en_out=pipe_en, all others 0.
  - pipe_en low: pc_en_out=0, ifid_stall=1, both flushes 0.
- Scoreboard update, on each edge with pipe_en=1: sb[k] <= sb[k-1] for k>=1; sb[0] <= ID fields with valid = id_valid & ~branch_taken & ~loaduse, otherwise an all-zero bubble.
- fwd_sel update, same edge: for each i, smallest k in 1..FWD_DEPTH with Match(i,k-1), evaluated on pre-shift scoreboard; 0 if none or if the incoming entry is a bubble. The nearest producer wins.
- Counters: stall_cnt +1 per edge with pipe_en and load-use and not branch_taken. flush_cnt +1 per edge with pipe_en and branch_taken. Both saturate at all-ones. cnt_clr wins over increment.
- pipe_en=0: scoreboard, fwd_sel and counters hold. cnt_clr still applies.

## Timing
- Reset, asynchronous: scoreboard all invalid, fwd_sel=0, counters=0. While rst=1: pc_en_out=0, ifid_stall=0, ifid_flush=1, idexe_flush=1.
- First cycle after release with pipe_en=1: pc_en_out=1.
- Stall and flush are combinational, zero latency, and act at the next edge. fwd_sel and counters are registered, one-cycle latency.
- Load-use costs exactly one bubble. After it, the load is in sb[1] and the dependent's fwd_sel = 2 (requires FWD_DEPTH>=2).
- Back-to-back branch_taken: each cycle flushes and counts.
- Reset mid-stall or mid-flush discards all in-flight entries. No hazard is reported until new instructions enter.

## Test plan
- Reset: rst=1 then release, pipe_en=1, no instructions -> pc_en_out=1, fwd_sel=0, both counters 0. During rst both flushes are 1.
- ALU chain: r1<=.. then r2<=r1+r1 (src0=src1=1 used) -> no stall; while second is in EXE, fwd_sel src0=1, src1=1. With one independent op between them -> select 2.
- Load-use: load r3, then add using src2=r3 -> exactly one cycle with pc_en_out=0, ifid_stall=1, idexe_flush=1; stall_cnt=1; consumer in EXE with fwd_sel src2=2.
- Branch plus hazard: branch_taken=1 in the same cycle as a load-use condition -> ifid_flush=idexe_flush=1, ifid_stall=0, flush_cnt=1, stall_cnt unchanged. The next instruction's fwd_sel ignores the flushed slot.
- R0_ZERO=1: producer writes r0, consumer reads r0 -> fwd_sel=0, no stall. Repeat with R0_ZERO=0 -> fwd_sel=1.
- Counters and freeze: CNT_W=4, 20 taken branches -> flush_cnt=15, saturated. pipe_en=0 for 3 cycles -> scoreboard and counts frozen, pc_en_out=0. cnt_clr -> both counters 0.
